fpga_ccff_io_harness: RTL and testbench
=======================================

Name: fpga_ccff_io_harness

Overview:
- User-area harness connecting the FPGA fabric's configuration chain (ccff) and scan chain (sc) to the 38 user GPIO pads (mprj_io).
- Decodes the fixed pad map, implements a BITSTREAM_SIZE-bit configuration shift register and an SC_LENGTH-bit scan shift register, and drives the chain tails back out on pads.
- The configuration bits are exported to the fabric.
- The SoC-level bench loads the bitstream serially through pads and checks the tail pulse.

Parameters:
- BITSTREAM_SIZE, 64, number of configuration-chain flops (≥2).
- SC_LENGTH, 32, number of scan-chain flops (≥2).

Ports:
- prog_clk  in  1  programming clock; the only clock; all flops are on its rising edge.
- prog_reset  in  1  synchronous, active-high reset.
- io_in  in  38  pad inputs (mprj_io).
- io_out  out  38  pad outputs.
- io_oeb  out  38  pad output-enable, active-low.
- config_bits  out  BITSTREAM_SIZE  configuration register contents; bit 0 is the head stage.
- config_done  out  1  set once BITSTREAM_SIZE bits have been shifted since reset.
- fabric_reset  out  1  operating reset to the fabric (= io_in[2]).
- fabric_test_en  out  1  = io_in[0].

Behaviour:
- Pad map, inputs:
  - io_in[0] Test_en.
  - io_in[1] IO_ISOL_N.
  - io_in[2] Reset (active-high).
  - io_in[3] pReset (active-low programming reset).
  - io_in[12] ccff_head.
  - io_in[25] LA/IO select (ignored).
  - io_in[26] sc_head.
  - io_in[36] op_clk (unused here).
  - io_in[37] prog_clk pad; tie it to the prog_clk port at top level.
- Pad map, outputs:
  - io_out[35] = ccff_tail.
  - io_out[11] = sc_tail.
  - io_oeb[35] = io_oeb[11] = 0; all other io_oeb bits = 1.
  - All other io_out bits = 0.
- Programming clear (clr_p) = prog_reset OR NOT io_in[3]; sampled synchronously.
- clr_p = 1 for a cycle: configuration chain all 0, count = 0, config_done = 0.
- Configuration chain, when clr_p = 0: shifts every rising edge with no enable.
  - stage[0] <= io_in[12]; stage[i] <= stage[i-1].
  - ccff_tail = stage[BITSTREAM_SIZE-1], a registered output.
  - Latency head→tail is exactly BITSTREAM_SIZE edges.
  - A 1 sampled at edge 1 appears on the tail after edge BITSTREAM_SIZE and leaves it after edge BITSTREAM_SIZE+1.
- Bit counter: increments on each shift edge and saturates at BITSTREAM_SIZE.
  - config_done = 1 when count == BITSTREAM_SIZE, a registered output.
  - It stays 1 until clr_p.
- Scan clear (clr_s) = prog_reset OR io_in[2], synchronous; it zeroes the scan chain.
- Scan chain, when clr_s = 0:
  - Test_en = 1: shift, s[0] <= io_in[26].
  - Test_en = 0: hold.
- sc_tail = s[SC_LENGTH-1] AND io_in[1]; isolation forces 0 when IO_ISOL_N = 0.
- ccff_tail is never isolated.
- config_bits = configuration stages, a direct register view.
- Reset values:
  - All registers 0.
  - io_out[35] = io_out[11] = 0.
  - io_oeb is constant.
  - fabric_reset and fabric_test_en are combinational from pads.
- Reset mid-stream: the next edge clears both chains and the counter. Shifting resumes the following edge with no residual bits.
- Simultaneous clr_p and shift: clear wins.
- Simultaneous clr_s and Test_en = 1: clear wins.

Test Plan:
- Reset: prog_reset = 1 for 2 edges → io_out[35] = 0, io_out[11] = 0, config_done = 0, config_bits = 0; io_oeb = all 1 except bits 11 and 35 = 0.
- Single-pulse load:
  - Stimulus: release reset; ccff_head = 1 before edge 1, then 0; BITSTREAM_SIZE = 64.
  - Response: tail = 1 after edge 64; tail = 0 after edges 65, 66 and 67; config_done = 1 from edge 64 on.
- Pattern load: shift 0xA5 followed by zeros for 64 edges → config_bits[7:0] = 0xA5 in reverse shift order (last bit shifted in at bit 0). Check the tail stream equals the head stream delayed by 64.
- pReset mid-load: drive io_in[3] = 0 for 1 edge after 30 shifts → config_bits = 0 and count restarts; config_done rises only 64 shifts later.
- Scan chain:
  - Test_en = 1, sc_head = 1 for one edge with IO_ISOL_N = 1 → sc_tail = 1 exactly after edge 32.
  - Test_en = 0 holds the value.
  - IO_ISOL_N = 0 forces io_out[11] = 0.
- Reset (io_in[2]) = 1: scan chain cleared and fabric_reset = 1; the configuration chain is unaffected.

Source files
------------

// File: rtl/fpga_ccff_io_harness.sv
// User-area harness: maps the mprj_io pads onto the fabric configuration chain (ccff) and
// scan chain (sc), and returns both chain tails on dedicated output pads.
module fpga_ccff_io_harness #(
  parameter int unsigned BITSTREAM_SIZE = 64,
  parameter int unsigned SC_LENGTH      = 32
) (
  input  logic                      prog_clk,
  input  logic                      prog_reset,
  input  logic [37:0]               io_in,
  output logic [37:0]               io_out,
  output logic [37:0]               io_oeb,
  output logic [BITSTREAM_SIZE-1:0] config_bits,
  output logic                      config_done,
  output logic                      fabric_reset,
  output logic                      fabric_test_en
);

  localparam int unsigned PadTestEn   = 0;
  localparam int unsigned PadIsolN    = 1;
  localparam int unsigned PadReset    = 2;
  localparam int unsigned PadPresetN  = 3;
  localparam int unsigned PadScTail   = 11;
  localparam int unsigned PadCcffHead = 12;
  localparam int unsigned PadScHead   = 26;
  localparam int unsigned PadCcffTail = 35;

  localparam int unsigned CntW = $clog2(BITSTREAM_SIZE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(BITSTREAM_SIZE);

  logic                      clr_p, clr_s;
  logic [BITSTREAM_SIZE-1:0] ccff_q, ccff_d;
  logic [SC_LENGTH-1:0]      scan_q, scan_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      ccff_tail, sc_tail;

  // LA select, op_clk, the prog_clk pad and the spare pads carry nothing for this block.
  logic unused_pads;
  assign unused_pads = ^{io_in[37:27], io_in[25], io_in[24:13], io_in[11:4]};

  assign clr_p = prog_reset | ~io_in[PadPresetN];
  assign clr_s = prog_reset | io_in[PadReset];

  always_comb begin
    ccff_d = ccff_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_p) begin
      ccff_d = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else begin
      ccff_d = {ccff_q[BITSTREAM_SIZE-2:0], io_in[PadCcffHead]};
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
      done_d = (cnt_d == CntMax);
    end
  end

  always_comb begin
    scan_d = scan_q;
    if (clr_s) begin
      scan_d = '0;
    end else if (io_in[PadTestEn]) begin
      scan_d = {scan_q[SC_LENGTH-2:0], io_in[PadScHead]};
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      ccff_q <= '0;
      scan_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ccff_q <= ccff_d;
      scan_q <= scan_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign ccff_tail = ccff_q[BITSTREAM_SIZE-1];
  // Isolation gates only the scan tail; the config tail must stay visible during programming.
  assign sc_tail   = scan_q[SC_LENGTH-1] & io_in[PadIsolN];

  always_comb begin
    io_out              = '0;
    io_out[PadCcffTail] = ccff_tail;
    io_out[PadScTail]   = sc_tail;
    io_oeb              = '1;
    io_oeb[PadCcffTail] = 1'b0;
    io_oeb[PadScTail]   = 1'b0;
  end

  assign config_bits    = ccff_q;
  assign config_done    = done_q;
  assign fabric_reset   = io_in[PadReset];
  assign fabric_test_en = io_in[PadTestEn];

endmodule

// File: tb/tb_fpga_ccff_io_harness.sv
// Directed bench for fpga_ccff_io_harness; queue scoreboards predict both chain tails.
module tb_fpga_ccff_io_harness;
  localparam int BS = 64;
  localparam int SC = 32;
  localparam logic [37:0] OebExp = ~((38'd1 << 35) | (38'd1 << 11));

  logic        clk = 1'b0;
  logic        prog_reset = 1'b1;
  logic [36:0] pad = '0;
  wire  [37:0] io_in = {clk, pad};
  logic [37:0] io_out, io_oeb;
  logic [BS-1:0] config_bits;
  logic        config_done, fabric_reset, fabric_test_en;

  int n_checks = 0;
  int n_pass = 0;
  bit cq[$];
  bit sq[$];
  int cnt_m = 0;

  always #5 clk = ~clk;

  fpga_ccff_io_harness #(.BITSTREAM_SIZE(BS), .SC_LENGTH(SC)) dut (
    .prog_clk      (clk),
    .prog_reset    (prog_reset),
    .io_in         (io_in),
    .io_out        (io_out),
    .io_oeb        (io_oeb),
    .config_bits   (config_bits),
    .config_done   (config_done),
    .fabric_reset  (fabric_reset),
    .fabric_test_en(fabric_test_en)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock edge with the given pad values, then scoreboard update and checks.
  task automatic step(input logic ch, input logic sh, input logic ten, input logic isn,
                      input logic rpad, input logic prn, input logic prst);
    logic exp_ct, exp_st;
    pad = '0;
    pad[0] = ten;
    pad[1] = isn;
    pad[2] = rpad;
    pad[3] = prn;
    pad[12] = ch;
    pad[26] = sh;
    prog_reset = prst;
    @(posedge clk);
    #1;
    if (prst || !prn) begin
      cq.delete();
      cnt_m = 0;
    end else begin
      cq.push_back(ch);
      if (cq.size() > BS) void'(cq.pop_front());
      if (cnt_m < BS) cnt_m++;
    end
    if (prst || rpad) sq.delete();
    else if (ten) begin
      sq.push_back(sh);
      if (sq.size() > SC) void'(sq.pop_front());
    end
    exp_ct = (cq.size() == BS) ? cq[0] : 1'b0;
    exp_st = ((sq.size() == SC) ? sq[0] : 1'b0) & isn;
    check("ccff_tail", io_out[35], exp_ct);
    check("sc_tail", io_out[11], exp_st);
    check("config_done", config_done, (cnt_m == BS));
    check("fabric_reset", fabric_reset, rpad);
    check("fabric_test_en", fabric_test_en, ten);
    check("io_oeb", io_oeb, OebExp);
    check("io_out_spare", io_out & OebExp, 38'd0);
  endtask

  task automatic shift(input logic ch);
    step(ch, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0]    pat;
    logic [BS-1:0] cfg_before;
    pat = 8'hA5;

    // Reset
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("reset_config_bits", config_bits, 64'd0);

    // Single pulse through the configuration chain
    shift(1'b1);
    for (int e = 2; e <= 67; e++) begin
      shift(1'b0);
      if (e == 63) check("pulse_done_63", config_done, 1'b0);
      if (e == 64) check("pulse_tail_64", io_out[35], 1'b1);
      if (e >= 65) check("pulse_tail_gone", io_out[35], 1'b0);
      if (e >= 64) check("pulse_done_held", config_done, 1'b1);
    end

    // Pattern load, last shifted bit lands in bit 0
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 56; i++) shift(1'b0);
    for (int i = 7; i >= 0; i--) shift(pat[i]);
    check("pattern_config_bits", config_bits, 64'hA5);
    for (int i = 0; i < 64; i++) shift(1'b0);
    check("pattern_flushed", config_bits, 64'd0);

    // pReset mid-load
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) shift(1'($urandom_range(0, 1)));
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("preset_config_bits", config_bits, 64'd0);
    for (int e = 1; e <= 64; e++) begin
      shift(1'b1);
      if (e == 63) check("preset_done_63", config_done, 1'b0);
      if (e == 64) check("preset_done_64", config_done, 1'b1);
    end
    check("preset_all_ones", config_bits, {BS{1'b1}});

    // Scan chain shift, hold and isolation
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int e = 2; e <= 32; e++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      if (e == 31) check("scan_tail_31", io_out[11], 1'b0);
      if (e == 32) check("scan_tail_32", io_out[11], 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("scan_hold", io_out[11], 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("scan_isolated", io_out[11], 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("scan_unisolated", io_out[11], 1'b1);

    // Fabric reset clears scan only; clear wins over Test_en
    cfg_before = config_bits;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_pad_fabric_reset", fabric_reset, 1'b1);
    check("rst_pad_config_bits", config_bits, {cfg_before[BS-2:0], 1'b1});
    check("rst_pad_done", config_done, 1'b1);
    for (int i = 0; i < SC; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("scan_refilled", io_out[11], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
